// File: rtl/dma_request_arbiter_if.sv
// Request/acknowledge bundle between the DMA arbiter (slave side) and the
// system that drives channel requests and hold-acknowledge (master side).
interface dma_request_arbiter_if;
    logic [3:0] dreq;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       sw_req_wr;
    logic [3:0] sw_req_data;
    logic       hlda;
    logic       xfer_done;
    logic       hrq;
    logic [3:0] dack;
    logic [1:0] chan;
    logic       chan_valid;
    logic       busy;

    modport master (
        output dreq, mask_wr, mask_data, sw_req_wr, sw_req_data, hlda, xfer_done,
        input  hrq, dack, chan, chan_valid, busy
    );

    modport slave (
        input  dreq, mask_wr, mask_data, sw_req_wr, sw_req_data, hlda, xfer_done,
        output hrq, dack, chan, chan_valid, busy
    );
endinterface

// File: rtl/dma_request_arbiter.sv
// Four-channel DMA request arbiter: hold-request handshake plus one-hot grant.
// Define ROTATING_PRIORITY_EN for rotating priority; the default is fixed (channel 0 highest).
module dma_request_arbiter (
    input logic                   clk,
    input logic                   reset,
    dma_request_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;

    state_t     state;
    logic [3:0] mask;
    logic [3:0] sw_req;
    logic [3:0] pending;
    logic [3:0] sw_clr;
    logic [1:0] winner;

`ifdef ROTATING_PRIORITY_EN
    logic [1:0] top;
    logic [7:0] doubled;
    logic [3:0] rotated;

    // Rotate pending so the current top-priority channel lands on bit 0.
    assign doubled = {pending, pending} >> top;
    assign rotated = doubled[3:0];

    always_comb begin
        winner = top;
        for (int i = 3; i >= 0; i--) begin
            if (rotated[i]) winner = top + 2'(i);
        end
    end
`else
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending[i]) winner = 2'(i);
        end
    end
`endif

    assign pending = (bus.dreq | sw_req) & ~mask;

    // Completion clears the granted channel's software request; a same-cycle write still wins.
    always_comb begin
        sw_clr = 4'b0000;
        if (state == GRANT && bus.xfer_done) sw_clr[bus.chan] = 1'b1;
    end

    // NOTE: all state and outputs are registered with non-blocking assignments;
    // the mask resets to all-masked so no channel is served before software enables it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            mask           <= 4'b1111;
            sw_req         <= 4'b0000;
            bus.hrq        <= 1'b0;
            bus.dack       <= 4'b0000;
            bus.chan       <= 2'd0;
            bus.chan_valid <= 1'b0;
            bus.busy       <= 1'b0;
`ifdef ROTATING_PRIORITY_EN
            top            <= 2'd0;
`endif
        end else begin
            if (bus.mask_wr) mask <= bus.mask_data;
            sw_req <= (sw_req & ~sw_clr) | (bus.sw_req_wr ? bus.sw_req_data : 4'b0000);

            case (state)
                IDLE: begin
                    if (|pending) begin
                        state    <= REQ;
                        bus.hrq  <= 1'b1;
                        bus.busy <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.hlda) begin
                        if (|pending) begin
                            state          <= GRANT;
                            bus.chan       <= winner;
                            bus.dack       <= 4'b0001 << winner;
                            bus.chan_valid <= 1'b1;
                        end else begin
                            state   <= RELEASE;
                            bus.hrq <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    // Only completion ends a grant; mask, dreq and hlda changes are ignored here.
                    if (bus.xfer_done) begin
                        state          <= RELEASE;
                        bus.hrq        <= 1'b0;
                        bus.dack       <= 4'b0000;
                        bus.chan_valid <= 1'b0;
`ifdef ROTATING_PRIORITY_EN
                        top            <= bus.chan + 2'd1;
`endif
                    end
                end
                RELEASE: begin
                    if (!bus.hlda) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
